id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/alu_decode.sv | 86 ++++++++
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU operation codes, opcodes
// and the decoded entry carried through the stage buffer.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1100;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an R-type / I-type ALU instruction into a stage entry.
// Unsupported encodings become an illegal ADD with zeroed operands.
module alu_decode
    import id_ex_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output entry_t      entry
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        legal;
    logic [3:0]  ctrl;
    logic [31:0] operand2;
    logic        unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register indices are resolved by the register file, not here.
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        legal    = 1'b0;
        ctrl     = ALU_ADD;
        operand2 = rs2_data;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        ctrl  = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: begin legal = (funct7 == F7_BASE); ctrl = ALU_AND; end
                    3'b110: begin legal = (funct7 == F7_BASE); ctrl = ALU_OR;  end
                    3'b100: begin legal = (funct7 == F7_BASE); ctrl = ALU_XOR; end
                    3'b010: begin legal = (funct7 == F7_BASE); ctrl = ALU_SLT; end
                    3'b001: begin legal = (funct7 == F7_BASE); ctrl = ALU_SLL; end
                    3'b101: begin legal = (funct7 == F7_ALT);  ctrl = ALU_SRA; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                operand2 = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'b000: begin legal = 1'b1; ctrl = ALU_ADD; end
                    3'b111: begin legal = 1'b1; ctrl = ALU_AND; end
                    3'b110: begin legal = 1'b1; ctrl = ALU_OR;  end
                    3'b100: begin legal = 1'b1; ctrl = ALU_XOR; end
                    3'b010: begin legal = 1'b1; ctrl = ALU_SLT; end
                    // Shifts take only the 5-bit shamt; the upper bits select the variant.
                    3'b001: begin
                        operand2 = {27'b0, instr[24:20]};
                        legal    = (funct7 == F7_BASE);
                        ctrl     = ALU_SLL;
                    end
                    3'b101: begin
                        operand2 = {27'b0, instr[24:20]};
                        legal    = (funct7 == F7_ALT);
                        ctrl     = ALU_SRA;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        entry    = '0;
        entry.rd = instr[11:7];
        if (legal) begin
            entry.ctrl    = ctrl;
            entry.src1    = rs1_data;
            entry.src2    = operand2;
            entry.illegal = 1'b0;
        end else begin
            entry.ctrl    = ALU_ADD;
            entry.src1    = 32'd0;
            entry.src2    = 32'd0;
            entry.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes at the input and buffers decoded entries in a
// 2-deep FIFO whose head drives the ALU operands.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  ALU_control_o,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    entry_t     dec_entry;
    entry_t     mem [2];
    entry_t     head;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       ready_q;
    logic       push;
    logic       pop;

    alu_decode u_decode (
        .instr    (instr_i),
        .rs1_data (rs1_data_i),
        .rs2_data (rs2_data_i),
        .entry    (dec_entry)
    );

    // Handshake: an entry moves only on valid&ready of the same side at a
    // rising edge; valid never depends on ready, and in_ready is a register.
    assign push        = in_valid_i & ready_q;
    assign pop         = out_valid_o & out_ready_i;
    assign out_valid_o = (count != 2'd0);
    assign in_ready_o  = ready_q;

    always_comb begin
        count_next = count;
        if (flush_i) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            ready_q <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            if (flush_i) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= dec_entry;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

    // Data outputs read as zero whenever nothing is presented.
    assign head          = out_valid_o ? mem[rd_ptr] : '0;
    assign ALU_control_o = head.ctrl;
    assign src1_o        = head.src1;
    assign src2_o        = head.src2;
    assign rd_o          = head.rd;
    assign illegal_o     = head.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a queue-based reference of the stage buffer and an ISA-level decoder.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  ALU_control_o;
    logic [31:0] src1_o;
    logic [31:0] src2_o;
    logic [4:0]  rd_o;
    logic        illegal_o;

    int checks = 0;
    int fails  = 0;

    entry_t      exp_q[$];
    logic        m_ready;
    logic [75:0] obs;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .instr_i       (instr_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .ALU_control_o (ALU_control_o),
        .src1_o        (src1_o),
        .src2_o        (src2_o),
        .rd_o          (rd_o),
        .illegal_o     (illegal_o)
    );

    assign obs = {out_valid_o, in_ready_o, ALU_control_o, src1_o, src2_o, rd_o, illegal_o};

    // ISA-level reference decoder: operation chosen by funct3 from a table,
    // legality from which funct7 values each instruction form admits.
    function automatic entry_t ref_decode(logic [31:0] ins, logic [31:0] rs1, logic [31:0] rs2);
        logic [3:0] op_by_f3 [8];
        logic [2:0] f3;
        logic       is_r, is_i, base, alt, shift, ok;
        entry_t     e;
        op_by_f3 = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_ADD, ALU_XOR, ALU_SRA, ALU_OR, ALU_AND};
        f3    = ins[14:12];
        is_r  = (ins[6:0] == 7'h33);
        is_i  = (ins[6:0] == 7'h13);
        base  = (ins[31:25] == 7'h00);
        alt   = (ins[31:25] == 7'h20);
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        ok = 1'b0;
        if (f3 != 3'd3) begin
            if (is_r) ok = (f3 == 3'd0) ? (base || alt) : (f3 == 3'd5) ? alt : base;
            if (is_i) ok = (f3 == 3'd1) ? base : (f3 == 3'd5) ? alt : 1'b1;
        end
        e = '0;
        e.rd = ins[11:7];
        if (ok) begin
            e.ctrl = (is_r && f3 == 3'd0 && alt) ? ALU_SUB : op_by_f3[f3];
            e.src1 = rs1;
            if (is_r)       e.src2 = rs2;
            else if (shift) e.src2 = 32'(ins[24:20]);
            else            e.src2 = 32'(signed'(ins[31:20]));
        end else begin
            e.ctrl    = ALU_ADD;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [75:0] expected_view();
        entry_t h;
        logic   v;
        h = '0;
        v = (exp_q.size() > 0);
        if (v) h = exp_q[0];
        return {v, m_ready, h};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy, input logic fl);
        in_valid_i  = v;
        instr_i     = ins;
        rs1_data_i  = r1;
        rs2_data_i  = r2;
        out_ready_i = ordy;
        flush_i     = fl;
    endtask

    // Advance one clock and move the reference buffer by the same handshakes.
    task automatic cycle();
        logic   push_m, pop_m;
        entry_t e;
        push_m = in_valid_i && m_ready;
        pop_m  = (exp_q.size() > 0) && out_ready_i;
        e      = ref_decode(instr_i, rs1_data_i, rs2_data_i);
        @(posedge clk_i);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            m_ready = 1'b0;
        end else if (flush_i) begin
            exp_q.delete();
            m_ready = 1'b1;
        end else begin
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(e);
            m_ready = (exp_q.size() < 2);
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n   = 1'b1;
        m_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 76'd0) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h", obs, 76'd0);
        end
        cycle();
        cycle();
        checks++;
        if (obs !== 76'd0) begin
            fails++;
            $display("FAIL reset_held: got %h expected %h", obs, 76'd0);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (in_ready_o !== 1'b1 || obs !== expected_view()) begin
            fails++;
            $display("FAIL reset_release: got %h expected %h", obs, expected_view());
        end
    endtask

    task automatic test_add();
        drive(1, 32'h002081B3, 32'd5, 32'd7, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({out_valid_o, ALU_control_o, src1_o, src2_o, rd_o, illegal_o} !==
            {1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b0}) begin
            fails++;
            $display("FAIL add_vector: got %h expected valid ADD 5,7 rd3", obs);
        end
        drive(0, 0, 0, 0, 1, 0);
        cycle();
        checks++;
        if (obs !== expected_view()) begin
            fails++;
            $display("FAIL add_drain: got %h expected %h", obs, expected_view());
        end
    endtask

    task automatic test_shift_imm();
        drive(1, 32'h40435293, 32'h80000000, $urandom, 0, 0);
        cycle();
        checks++;
        if ({out_valid_o, ALU_control_o, src1_o, src2_o, rd_o, illegal_o} !==
            {1'b1, 4'b1101, 32'h80000000, 32'd4, 5'd5, 1'b0}) begin
            fails++;
            $display("FAIL srai_vector: got %h expected valid SRA 80000000,4 rd5", obs);
        end
        drive(1, 32'h00435293, $urandom, $urandom, 1, 0);
        cycle();
        checks++;
        if ({out_valid_o, ALU_control_o, src1_o, src2_o, rd_o, illegal_o} !==
            {1'b1, 4'b0010, 32'd0, 32'd0, 5'd5, 1'b1}) begin
            fails++;
            $display("FAIL srli_illegal: got %h expected illegal ADD 0,0 rd5", obs);
        end
        drive(0, 0, 0, 0, 1, 0);
        cycle();
        checks++;
        if (obs !== expected_view()) begin
            fails++;
            $display("FAIL shift_drain: got %h expected %h", obs, expected_view());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] prog [3];
        prog = '{32'h002081B3, 32'h40208233, 32'h0020C2B3};
        for (int i = 0; i < 3; i++) begin
            drive(1, prog[i], 32'd10 + 32'(i), 32'd3, 0, 0);
            cycle();
            checks++;
            if (obs !== expected_view()) begin
                fails++;
                $display("FAIL bp_fill[%0d]: got %h expected %h", i, obs, expected_view());
            end
        end
        checks++;
        if (in_ready_o !== 1'b0 || rd_o !== 5'd3) begin
            fails++;
            $display("FAIL bp_full: got ready=%b rd=%0d expected ready=0 rd=3", in_ready_o, rd_o);
        end
        drive(0, 0, 0, 0, 1, 0);
        cycle();
        checks++;
        if (in_ready_o !== 1'b1 || ALU_control_o !== 4'b0110 || rd_o !== 5'd4) begin
            fails++;
            $display("FAIL bp_order: got ready=%b ctrl=%b rd=%0d expected ready=1 ctrl=0110 rd=4",
                     in_ready_o, ALU_control_o, rd_o);
        end
        cycle();
        checks++;
        if (obs !== expected_view()) begin
            fails++;
            $display("FAIL bp_drain: got %h expected %h", obs, expected_view());
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 32'h002081B3, 32'd1, 32'd2, 0, 0);
        cycle();
        drive(1, 32'h0020C2B3, 32'd4, 32'd8, 1, 0);
        cycle();
        checks++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 || rd_o !== 5'd5 || ALU_control_o !== 4'b1001) begin
            fails++;
            $display("FAIL push_pop_at_one: got %h expected valid XOR rd5 ready", obs);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, rand_instr(), $urandom, $urandom, 1, 0);
            cycle();
            checks++;
            if (obs !== expected_view() || out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL stream[%0d]: got %h expected %h", i, obs, expected_view());
            end
        end
        drive(0, 0, 0, 0, 1, 0);
        cycle();
    endtask

    task automatic test_flush();
        drive(1, 32'h002081B3, 32'd1, 32'd2, 0, 0);
        cycle();
        drive(1, 32'h40208233, 32'd3, 32'd4, 0, 0);
        cycle();
        drive(1, 32'h0020C2B3, 32'd5, 32'd6, 1, 1);
        cycle();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || obs !== expected_view()) begin
            fails++;
            $display("FAIL flush_full: got %h expected empty and ready", obs);
        end
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (out_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_push: got valid=%b expected 0", out_valid_o);
        end
    endtask

    task automatic test_random();
        logic pending;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            pending = in_valid_i && !(m_ready && !flush_i);
            if (!pending) begin
                in_valid_i = ($urandom_range(0, 3) != 0);
                instr_i    = rand_instr();
                rs1_data_i = $urandom;
                rs2_data_i = $urandom;
            end
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 29) == 0);
            cycle();
            checks++;
            if (obs !== expected_view()) begin
                fails++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, expected_view());
            end
        end
        drive(0, 0, 0, 0, 1, 0);
        cycle();
        cycle();
    endtask

    task automatic test_async_reset();
        drive(1, 32'h002081B3, 32'd1, 32'd2, 0, 0);
        cycle();
        drive(1, 32'h40208233, 32'd3, 32'd4, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_ready = 1'b0;
        checks++;
        if (obs !== 76'd0) begin
            fails++;
            $display("FAIL async_reset: got %h expected %h", obs, 76'd0);
        end
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        cycle();
        checks++;
        if (in_ready_o !== 1'b1 || obs !== expected_view()) begin
            fails++;
            $display("FAIL async_release: got %h expected %h", obs, expected_view());
        end
        drive(1, 32'h002081B3, 32'd9, 32'd9, 0, 0);
        cycle();
        checks++;
        if (obs !== expected_view()) begin
            fails++;
            $display("FAIL after_reset_push: got %h expected %h", obs, expected_view());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift_imm();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
